hc595_drv: RTL and testbench

Parallel-to-serial driver for a chain of hc595 shift/storage registers. Accepts a WIDTH-bit word over a ready/start handshake, serialises it onto `ser`/`srclk`, then pulses `rclk` so all chained outputs update together. Sits between core logic (LED/segment/relay state) and the board-level hc595 chain; one instance drives one chain.

---
 rtl/hc595_drv.sv | 126 ++++++++++++
 tb/tb_hc595_drv.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_drv.sv
// hc595_drv: parallel-to-serial driver for a chain of hc595 shift/storage registers.
// Takes a WIDTH-bit word on start/ready, shifts it out on ser/srclk, then pulses rclk
// so the whole chain updates at once. oe_n stays high until the first latch completes.
// Optional build macro: HC595_DRV_LSB_FIRST_EN shifts data[0] first (default MSB first).
module hc595_drv #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             done,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             srclr_n,
  output logic             oe_n
);

  localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH_SETUP,
    LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sr_q, sr_d, sr_shift;
  logic               phase_last, idx_last;
  logic               ser_d, ready_d, done_d, srclk_d, rclk_d;

`ifdef HC595_DRV_LSB_FIRST_EN
  localparam int unsigned HEAD = 0;
  assign sr_shift = sr_q >> 1;
`else
  localparam int unsigned HEAD = WIDTH - 1;
  assign sr_shift = sr_q << 1;
`endif

  assign phase_last = (phase_q == PH_W'(CLK_DIV - 1));
  assign idx_last   = (idx_q == IDX_W'(WIDTH - 1));

  // Next-state, datapath and next-output decode; outputs follow the state being entered
  always_comb begin
    state_d = state_q;
    phase_d = phase_last ? '0 : phase_q + PH_W'(1);
    idx_d   = idx_q;
    sr_d    = sr_q;
    ser_d   = ser;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start && ready) begin
          sr_d    = data;
          idx_d   = '0;
          ser_d   = data[HEAD];
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_last) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_last) begin
          if (idx_last) begin
            state_d = LATCH_SETUP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            sr_d    = sr_shift;
            ser_d   = sr_shift[HEAD];
            state_d = SHIFT_LO;
          end
        end
      end
      LATCH_SETUP: begin
        if (phase_last) state_d = LATCH;
      end
      LATCH: begin
        if (phase_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    srclk_d = (state_d == SHIFT_HI);
    rclk_d  = (state_d == LATCH);
    done_d  = (state_q == LATCH) && phase_last;
  end

  // State, datapath and registered outputs; srclr_n trails rst_n by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      ser     <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      srclr_n <= 1'b0;
      oe_n    <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      ready   <= ready_d;
      done    <= done_d;
      ser     <= ser_d;
      srclk   <= srclk_d;
      rclk    <= rclk_d;
      srclr_n <= 1'b1;
      if (done_d) oe_n <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hc595_drv.sv
// tb_hc595_drv: drives two hc595_drv instances (8-bit/div-2 and 16-bit/div-1) and
// compares against a board-level hc595 chain model built from the DUT pins.
module tb_hc595_drv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=8, CLK_DIV=2
  logic       a_start, a_ready, a_done, a_ser, a_srclk, a_rclk, a_srclr_n, a_oe_n;
  logic [7:0] a_data;
  // Instance B: WIDTH=16, CLK_DIV=1
  logic        b_start, b_ready, b_done, b_ser, b_srclk, b_rclk, b_srclr_n, b_oe_n;
  logic [15:0] b_data;

  hc595_drv #(.WIDTH(8), .CLK_DIV(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .data(a_data), .ready(a_ready),
    .done(a_done), .ser(a_ser), .srclk(a_srclk), .rclk(a_rclk),
    .srclr_n(a_srclr_n), .oe_n(a_oe_n));

  hc595_drv #(.WIDTH(16), .CLK_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .data(b_data), .ready(b_ready),
    .done(b_done), .ser(b_ser), .srclk(b_srclk), .rclk(b_rclk),
    .srclr_n(b_srclr_n), .oe_n(b_oe_n));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[15-i];
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // What the chain presents after a word has been latched
  function automatic logic [7:0] exp8(input logic [7:0] d);
`ifdef HC595_DRV_LSB_FIRST_EN
    return rev8(d);
`else
    return d;
`endif
  endfunction

  function automatic logic [15:0] exp16(input logic [15:0] d);
`ifdef HC595_DRV_LSB_FIRST_EN
    return rev16(d);
`else
    return d;
`endif
  endfunction

  // Bit expected on ser at the k-th srclk rise of an 8-bit word
  function automatic logic exp_bit8(input logic [7:0] d, input int k);
`ifdef HC595_DRV_LSB_FIRST_EN
    return d[k];
`else
    return d[7-k];
`endif
  endfunction

  // hc595 chain model A: shift on srclk rise, store on rclk rise, srclr clears shift stages
  logic [7:0] a_chain = '0, a_q = '0;
  logic a_srclk_p = 1'b0, a_rclk_p = 1'b0, a_ser_p = 1'b0;
  int a_rclk_rises = 0, a_rclk_hi = 0, a_dones = 0, a_stable = 0;
  bit a_bits[$];
  always @(negedge clk) begin
    if (a_ser !== a_ser_p) a_stable = 1; else a_stable++;
    if (a_srclr_n !== 1'b1) a_chain = '0;
    else if (a_srclk === 1'b1 && a_srclk_p === 1'b0) begin
      chk("a_ser_setup", 32'(a_stable > 2), 1);
      a_chain = {a_chain[6:0], a_ser};
      a_bits.push_back(a_ser);
    end
    if (a_rclk === 1'b1 && a_rclk_p === 1'b0) begin
      a_q = a_chain;
      a_rclk_rises++;
    end
    if (a_rclk === 1'b1) a_rclk_hi++;
    if (a_done === 1'b1) a_dones++;
    a_srclk_p = a_srclk;
    a_rclk_p  = a_rclk;
    a_ser_p   = a_ser;
  end

  // hc595 chain model B
  logic [15:0] b_chain = '0, b_q = '0;
  logic b_srclk_p = 1'b0, b_rclk_p = 1'b0, b_ser_p = 1'b0;
  int b_stable = 0, b_dones = 0;
  always @(negedge clk) begin
    if (b_ser !== b_ser_p) b_stable = 1; else b_stable++;
    if (b_srclr_n !== 1'b1) b_chain = '0;
    else if (b_srclk === 1'b1 && b_srclk_p === 1'b0) begin
      chk("b_ser_setup", 32'(b_stable > 1), 1);
      b_chain = {b_chain[14:0], b_ser};
    end
    if (b_rclk === 1'b1 && b_rclk_p === 1'b0) b_q = b_chain;
    if (b_done === 1'b1) b_dones++;
    b_srclk_p = b_srclk;
    b_rclk_p  = b_rclk;
    b_ser_p   = b_ser;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called in cycle 0; returns in cycle 1 with data scrambled
  task automatic a_accept(input logic [7:0] d);
    a_start = 1'b1;
    a_data  = d;
    step(1);
    a_start = 1'b0;
    a_data  = ~d;
  endtask

  task automatic a_wait_done(input int from, output int cyc);
    cyc = from;
    while (a_done !== 1'b1 && cyc < 400) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic b_wait_done(input int from, output int cyc);
    cyc = from;
    while (b_done !== 1'b1 && cyc < 400) begin
      step(1);
      cyc++;
    end
  endtask

  initial begin
    int cyc, d0, r0, h0;
    logic [7:0]  ad;
    logic [15:0] bd;

    rst_n = 1'b0;
    a_start = 1'b0; a_data = '0;
    b_start = 1'b0; b_data = '0;

    // Reset state
    step(3);
    chk("rst_ready", a_ready, 1);
    chk("rst_done", a_done, 0);
    chk("rst_ser", a_ser, 0);
    chk("rst_srclk", a_srclk, 0);
    chk("rst_rclk", a_rclk, 0);
    chk("rst_srclr_n", a_srclr_n, 0);
    chk("rst_oe_n", a_oe_n, 1);
    chk("rst_b_srclr_n", b_srclr_n, 0);
    rst_n = 1'b1;
    step(1);
    chk("rel_srclr_n", a_srclr_n, 1);
    chk("rel_b_srclr_n", b_srclr_n, 1);
    chk("rel_oe_n", a_oe_n, 1);

    // Single 8'hA5 transfer
    d0 = a_dones; r0 = a_rclk_rises; h0 = a_rclk_hi;
    a_bits.delete();
    a_accept(8'hA5);
    chk("a5_busy", a_ready, 0);
    step(35);
    chk("a5_oe_still_off", a_oe_n, 1);
    chk("a5_no_early_done", a_done, 0);
    a_wait_done(36, cyc);
    chk("a5_done_cycle", 32'(cyc), 37);
    chk("a5_ready", a_ready, 1);
    chk("a5_q", a_q, exp8(8'hA5));
    chk("a5_nbits", 32'(a_bits.size()), 8);
    for (int k = 0; k < 8 && k < a_bits.size(); k++)
      chk($sformatf("a5_ser_bit%0d", k), a_bits[k], exp_bit8(8'hA5, k));
    chk("a5_rclk_pulses", 32'(a_rclk_rises - r0), 1);
    chk("a5_rclk_width", 32'(a_rclk_hi - h0), 2);
    chk("a5_oe_on", a_oe_n, 0);
    step(1);
    chk("a5_done_pulse", 32'(a_dones - d0), 1);
    chk("a5_done_one_cycle", a_done, 0);

    // Back-to-back: start held high through the first transfer and its done cycle
    d0 = a_dones;
    a_start = 1'b1; a_data = 8'h3C;
    step(1);
    a_wait_done(1, cyc);
    chk("b2b_first_cycle", 32'(cyc), 37);
    chk("b2b_first_q", a_q, exp8(8'h3C));
    a_data = 8'hC3;
    step(1);
    a_start = 1'b0;
    chk("b2b_no_gap", a_ready, 0);
    a_wait_done(1, cyc);
    chk("b2b_second_cycle", 32'(cyc), 37);
    chk("b2b_second_q", a_q, exp8(8'hC3));
    step(3);
    chk("b2b_done_count", 32'(a_dones - d0), 2);

    // Start while busy is ignored
    d0 = a_dones;
    a_accept(8'h01);
    step(9);
    a_start = 1'b1; a_data = 8'hFF;
    step(1);
    a_start = 1'b0;
    a_wait_done(11, cyc);
    chk("ign_done_cycle", 32'(cyc), 37);
    chk("ign_q", a_q, exp8(8'h01));
    step(40);
    chk("ign_done_count", 32'(a_dones - d0), 1);

    // Reset mid-transfer
    r0 = a_rclk_rises;
    a_accept(8'hFF);
    step(11);
    rst_n = 1'b0;
    step(1);
    chk("mid_ready", a_ready, 1);
    chk("mid_oe_n", a_oe_n, 1);
    chk("mid_srclr_n", a_srclr_n, 0);
    chk("mid_srclk", a_srclk, 0);
    chk("mid_ser", a_ser, 0);
    step(1);
    chk("mid_chain_clear", a_chain, 0);
    rst_n = 1'b1;
    step(40);
    chk("mid_no_rclk", 32'(a_rclk_rises - r0), 0);
    chk("mid_chain_idle", a_chain, 0);

    // Randomised words with random idle gaps
    for (int i = 0; i < 6; i++) begin
      ad = 8'($urandom);
      step(int'($urandom_range(0, 3)));
      a_accept(ad);
      a_wait_done(1, cyc);
      chk($sformatf("rnd%0d_cycle", i), 32'(cyc), 37);
      chk($sformatf("rnd%0d_q", i), a_q, exp8(ad));
      chk($sformatf("rnd%0d_oe", i), a_oe_n, 0);
    end

    // 16-bit chain, CLK_DIV=1
    d0 = b_dones;
    b_start = 1'b1; b_data = 16'h1234;
    step(1);
    b_start = 1'b0; b_data = 16'hFFFF;
    b_wait_done(1, cyc);
    chk("w16_done_cycle", 32'(cyc), 35);
`ifdef HC595_DRV_LSB_FIRST_EN
    chk("w16_q", b_q, 16'h2C48);
`else
    chk("w16_q", b_q, 16'h1234);
`endif
    chk("w16_oe", b_oe_n, 0);
    for (int i = 0; i < 3; i++) begin
      bd = 16'($urandom);
      b_start = 1'b1; b_data = bd;
      step(1);
      b_start = 1'b0; b_data = ~bd;
      b_wait_done(1, cyc);
      chk($sformatf("w16_rnd%0d_cycle", i), 32'(cyc), 35);
      chk($sformatf("w16_rnd%0d_q", i), b_q, exp16(bd));
    end
    step(2);
    chk("w16_done_count", 32'(b_dones - d0), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
